// File: rtl/uart_word_serializer_if.sv
// uart_word_serializer_if: request/FIFO/status signals between the debug FSM,
// the word serializer and the UART TX FIFO.
interface uart_word_serializer_if #(
  parameter int DATA_LEN    = 8,
  parameter int DATA_IN_LEN = 32
);
  localparam int CNT_W = $clog2(DATA_IN_LEN / DATA_LEN) + 1;

  logic                   i_is_uart_full;
  logic                   i_wr;
  logic [DATA_IN_LEN-1:0] i_wr_data;
  logic [CNT_W-1:0]       i_wr_bytes;
  logic                   o_uart_wr;
  logic [DATA_LEN-1:0]    o_wr_buffer;
  logic                   o_busy;
  logic                   o_wr_finished;

  // Requester side: debug FSM plus the FIFO full flag.
  modport master (
    output i_is_uart_full, i_wr, i_wr_data, i_wr_bytes,
    input  o_uart_wr, o_wr_buffer, o_busy, o_wr_finished
  );

  // Serializer side.
  modport slave (
    input  i_is_uart_full, i_wr, i_wr_data, i_wr_bytes,
    output o_uart_wr, o_wr_buffer, o_busy, o_wr_finished
  );
endinterface

// File: rtl/uart_word_serializer.sv
// uart_word_serializer: splits a DATA_IN_LEN word into DATA_LEN chunks and writes
// them one at a time into the UART TX FIFO, honouring its full flag.
// Optional feature: define CHECKSUM_EN to append one XOR checksum chunk after the data.
module uart_word_serializer #(
  parameter int DATA_LEN    = 8,
  parameter int DATA_IN_LEN = 32,
  parameter int MSB_FIRST   = 0
) (
  input logic                   i_clk,
  input logic                   i_reset_n,
  uart_word_serializer_if.slave bus
);
  localparam int N     = DATA_IN_LEN / DATA_LEN;
  localparam int CNT_W = $clog2(N) + 1;
  // One spare bit so the pointer can also address the checksum slot.
  localparam int PTR_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, CHECK, STROBE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [DATA_IN_LEN-1:0] word_q, word_d;
  logic [PTR_W-1:0]       len_q, len_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [DATA_LEN-1:0]    buf_q, buf_d;
  logic                   wr_q, wr_d;
  logic                   busy_q, busy_d;
  logic                   fin_q, fin_d;
`ifdef CHECKSUM_EN
  logic [DATA_LEN-1:0]    acc_q, acc_d;
`endif

  logic [PTR_W-1:0]       req_len;
  logic [PTR_W-1:0]       total;
  logic [PTR_W-1:0]       chunk_idx;
  logic [DATA_LEN-1:0]    data_chunk;

  function automatic logic [DATA_LEN-1:0] chunk_sel(input logic [DATA_IN_LEN-1:0] w,
                                                    input logic [PTR_W-1:0]       idx);
    logic [DATA_LEN-1:0] c;
    c = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == PTR_W'(k)) c = w[k*DATA_LEN +: DATA_LEN];
    end
    return c;
  endfunction

  // Requested chunk count: 0 or anything above N means a full word.
  always_comb begin
    req_len = PTR_W'(bus.i_wr_bytes);
    if (req_len == '0 || req_len > PTR_W'(N)) req_len = PTR_W'(N);
  end

`ifdef CHECKSUM_EN
  assign total = len_q + PTR_W'(1);
`else
  assign total = len_q;
`endif

  // MSB-first walks the low len_q chunks from the top down; only evaluated while ptr < len.
  assign chunk_idx  = (MSB_FIRST != 0) ? (len_q - ptr_q - PTR_W'(1)) : ptr_q;
  assign data_chunk = chunk_sel(word_q, chunk_idx);

  // State and datapath registers; the asynchronous reset aborts a transfer immediately.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      len_q   <= '0;
      ptr_q   <= '0;
      buf_q   <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
`ifdef CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      buf_q   <= buf_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
`ifdef CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  // Next-state decision: accept, wait for FIFO room, strobe, finish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_wr) state_d = CHECK;
      CHECK: begin
        if (ptr_q == total)          state_d = DONE;
        else if (!bus.i_is_uart_full) state_d = STROBE;
      end
      STROBE:  state_d = CHECK;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and datapath updates for each state.
  always_comb begin
    word_d = word_q;
    len_d  = len_q;
    ptr_d  = ptr_q;
    buf_d  = buf_q;
    wr_d   = 1'b0;
    busy_d = busy_q;
    fin_d  = 1'b0;
`ifdef CHECKSUM_EN
    acc_d  = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_wr) begin
          word_d = bus.i_wr_data;
          len_d  = req_len;
          ptr_d  = '0;
          busy_d = 1'b1;
`ifdef CHECKSUM_EN
          acc_d  = '0;
`endif
        end
      end
      CHECK: begin
        if (ptr_q == total) begin
          // Pulse lands in the DONE cycle, while busy is still high.
          fin_d = 1'b1;
        end else if (!bus.i_is_uart_full) begin
          wr_d  = 1'b1;
          buf_d = data_chunk;
`ifdef CHECKSUM_EN
          if (ptr_q == len_q) buf_d = acc_q;
          else                acc_d = acc_q ^ data_chunk;
`endif
        end
      end
      STROBE:  ptr_d  = ptr_q + PTR_W'(1);
      DONE:    busy_d = 1'b0;
      default: ;
    endcase
  end

  assign bus.o_uart_wr     = wr_q;
  assign bus.o_wr_buffer   = buf_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_wr_finished = fin_q;
endmodule

// File: tb/tb_uart_word_serializer.sv
// tb_uart_word_serializer: drives an LSB-first and an MSB-first serializer with the
// same requests and FIFO-full pattern, and checks both chunk streams against a model.
module tb_uart_word_serializer;
  localparam int DL  = 8;
  localparam int DIL = 32;
  localparam int N   = DIL / DL;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        full  = 1'b0;
  logic        wr    = 1'b0;
  logic [31:0] data  = '0;
  logic [2:0]  bytes = '0;

  uart_word_serializer_if #(.DATA_LEN(DL), .DATA_IN_LEN(DIL)) bus0 ();
  uart_word_serializer_if #(.DATA_LEN(DL), .DATA_IN_LEN(DIL)) bus1 ();

  assign bus0.i_is_uart_full = full;
  assign bus0.i_wr           = wr;
  assign bus0.i_wr_data      = data;
  assign bus0.i_wr_bytes     = bytes;
  assign bus1.i_is_uart_full = full;
  assign bus1.i_wr           = wr;
  assign bus1.i_wr_data      = data;
  assign bus1.i_wr_bytes     = bytes;

  uart_word_serializer #(.DATA_LEN(DL), .DATA_IN_LEN(DIL), .MSB_FIRST(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus0));
  uart_word_serializer #(.DATA_LEN(DL), .DATA_IN_LEN(DIL), .MSB_FIRST(1)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus1));

  // Cycle counter and the full flag as seen by the edge that decides a strobe.
  int   cyc = 0;
  logic full_edge = 1'b0;
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    full_edge <= full;
  end

  // Output monitor: collects strobed chunks and counts protocol violations.
  logic [7:0] got0[$];
  logic [7:0] got1[$];
  int         scyc0[$];
  int         fin0 = 0, fin1 = 0, dbl = 0, fviol = 0, finlong = 0;
  logic       pwr0 = 1'b0, pwr1 = 1'b0, pfin0 = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus0.o_uart_wr) begin
        got0.push_back(bus0.o_wr_buffer);
        scyc0.push_back(cyc);
        if (pwr0)      dbl++;
        if (full_edge) fviol++;
      end
      if (bus1.o_uart_wr) begin
        got1.push_back(bus1.o_wr_buffer);
        if (pwr1)      dbl++;
        if (full_edge) fviol++;
      end
      if (bus0.o_wr_finished) fin0++;
      if (bus1.o_wr_finished) fin1++;
      if (bus0.o_wr_finished && pfin0) finlong++;
    end
    pwr0  = bus0.o_uart_wr;
    pwr1  = bus1.o_uart_wr;
    pfin0 = bus0.o_wr_finished;
  end

  int n_cmp = 0, n_fail = 0;
  int base0, base1, fb0, fb1, db, vb, lb, t_start;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];

  typedef struct {
    logic [31:0] w;
    logic [2:0]  b;
    int          n;
    logic [31:0] lsb;  // expected chunks in send order, first chunk in bits [7:0]
    logic [31:0] msb;
    logic [7:0]  ck;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: chunk k of the low L chunks, LSB order or reversed, optional XOR tail.
  task automatic build_model(input logic [31:0] w, input logic [2:0] b);
    int L;
    logic [7:0] x0, x1, c;
    exp0.delete();
    exp1.delete();
    L  = (b == 3'd0 || int'(b) > N) ? N : int'(b);
    x0 = '0;
    x1 = '0;
    for (int k = 0; k < L; k++) begin
      c = 8'(w >> (8 * k));
      exp0.push_back(c);
      x0 ^= c;
      c = 8'(w >> (8 * (L - 1 - k)));
      exp1.push_back(c);
      x1 ^= c;
    end
`ifdef CHECKSUM_EN
    exp0.push_back(x0);
    exp1.push_back(x1);
`endif
  endtask

  task automatic build_table(input int i);
    logic [31:0] l, m;
    l = tbl[i].lsb;
    m = tbl[i].msb;
    exp0.delete();
    exp1.delete();
    for (int k = 0; k < tbl[i].n; k++) begin
      exp0.push_back(l[8*k +: 8]);
      exp1.push_back(m[8*k +: 8]);
    end
`ifdef CHECKSUM_EN
    exp0.push_back(tbl[i].ck);
    exp1.push_back(tbl[i].ck);
`endif
  endtask

  task automatic start(input logic [31:0] w, input logic [2:0] b);
    @(posedge clk); #1;
    base0 = got0.size(); base1 = got1.size();
    fb0 = fin0; fb1 = fin1; db = dbl; vb = fviol; lb = finlong;
    wr = 1'b1; data = w; bytes = b; t_start = cyc;
    @(posedge clk); #1;
    wr = 1'b0; data = $urandom; bytes = 3'($urandom_range(0, 7));
    check("busy_after_accept", bus0.o_busy, 1);
  endtask

  task automatic wait_done(input bit rnd);
    bit seen;
    int drop;
    seen = 0;
    drop = 0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk);
      if (!bus0.o_busy) drop++;
      if (bus0.o_wr_finished) seen = 1;
      else if (rnd) begin
        @(posedge clk); #1;
        full = ($urandom_range(0, 2) == 0);
      end
    end
    check("done_seen", seen, 1);
    check("busy_held_until_done", drop, 0);
    @(posedge clk); #1;
    full = 1'b0;
    check("busy_low_after_done", bus0.o_busy, 0);
    check("done_single_cycle", bus0.o_wr_finished, 0);
  endtask

  task automatic verify(input string nm, input bit timing);
    check($sformatf("%s_count_lsb", nm), got0.size() - base0, exp0.size());
    check($sformatf("%s_count_msb", nm), got1.size() - base1, exp1.size());
    for (int k = 0; k < exp0.size(); k++) begin
      if (base0 + k < got0.size()) check($sformatf("%s_lsb%0d", nm, k), got0[base0+k], exp0[k]);
      if (base1 + k < got1.size()) check($sformatf("%s_msb%0d", nm, k), got1[base1+k], exp1[k]);
      if (timing && base0 + k < scyc0.size())
        check($sformatf("%s_cycle%0d", nm, k), scyc0[base0+k] - t_start, 2 + 2 * k);
    end
    check($sformatf("%s_done_pulses", nm), (fin0 - fb0) + (fin1 - fb1), 2);
    check($sformatf("%s_double_strobe", nm), dbl - db, 0);
    check($sformatf("%s_write_while_full", nm), fviol - vb, 0);
    check($sformatf("%s_long_done", nm), finlong - lb, 0);
  endtask

  task automatic wait_chunks(input int cnt);
    bit ok;
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk); #1;
      if (got0.size() >= base0 + cnt) ok = 1;
    end
    check("chunk_wait", ok, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    tbl[0] = '{32'hA1B2C3D4, 3'd4, 4, 32'hA1B2C3D4, 32'hD4C3B2A1, 8'h04};
    tbl[1] = '{32'hA1B2C3D4, 3'd2, 2, 32'h0000C3D4, 32'h0000D4C3, 8'h17};
    tbl[2] = '{32'hA1B2C3D4, 3'd0, 4, 32'hA1B2C3D4, 32'hD4C3B2A1, 8'h04};
    tbl[3] = '{32'hA1B2C3D4, 3'd7, 4, 32'hA1B2C3D4, 32'hD4C3B2A1, 8'h04};
    tbl[4] = '{32'h12345678, 3'd1, 1, 32'h00000078, 32'h00000078, 8'h78};
    tbl[5] = '{32'h89ABCDEF, 3'd3, 3, 32'h00ABCDEF, 32'h00EFCDAB, 8'h89};

    // Reset state, applied asynchronously before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_uart_wr", bus0.o_uart_wr, 0);
    check("rst_buffer", bus0.o_wr_buffer, 0);
    check("rst_busy", bus0.o_busy, 0);
    check("rst_finished", bus0.o_wr_finished, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed vectors with exact timing.
    for (int i = 0; i < 6; i++) begin
      start(tbl[i].w, tbl[i].b);
      wait_done(0);
      build_table(i);
      verify($sformatf("vec%0d", i), 1);
    end

    // FIFO full for 10 cycles after the first chunk.
    start(32'hA1B2C3D4, 3'd4);
    wait_chunks(1);
    @(posedge clk); #1;
    full = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("stall_no_strobe", got0.size() - base0, 1);
    check("stall_busy", bus0.o_busy, 1);
    full = 1'b0;
    wait_done(0);
    build_table(0);
    verify("stall", 0);

    // New request mid-transfer is dropped.
    start(32'hA1B2C3D4, 3'd4);
    wait_chunks(2);
    @(posedge clk); #1;
    wr = 1'b1; data = 32'h5A5A5A5A; bytes = 3'd4;
    @(posedge clk); #1;
    wr = 1'b0;
    wait_done(0);
    build_table(0);
    verify("midreq", 0);
    sent = got0.size();
    repeat (8) @(negedge clk);
    #1;
    check("midreq_not_queued", got0.size() - sent, 0);

    // Request presented in the done cycle is ignored.
    start(32'h12345678, 3'd1);
    for (int k = 0; k < 50 && !bus0.o_wr_finished; k++) @(negedge clk);
    check("done_cycle_reached", bus0.o_wr_finished, 1);
    wr = 1'b1; data = 32'hCAFEF00D; bytes = 3'd4;
    @(posedge clk); #1;
    wr = 1'b0;
    check("done_req_busy", bus0.o_busy, 0);
    sent = got0.size();
    repeat (6) @(negedge clk);
    #1;
    check("done_req_ignored", got0.size() - sent, 0);
    build_table(4);
    verify("donereq", 0);

    // Reset during the second strobe, then a fresh transfer.
    start(32'h11223344, 3'd4);
    wait_chunks(2);
    check("rst_mid_strobe_seen", bus0.o_uart_wr, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_wr0", bus0.o_uart_wr, 0);
    check("rst_async_busy0", bus0.o_busy, 0);
    check("rst_async_wr1", bus1.o_uart_wr, 0);
    check("rst_async_buf0", bus0.o_wr_buffer, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    start(32'h55667788, 3'd4);
    wait_done(0);
    build_model(32'h55667788, 3'd4);
    verify("after_rst", 1);

    // Random words, lengths and FIFO back-pressure.
    for (int i = 0; i < 30; i++) begin
      logic [31:0] w;
      logic [2:0]  b;
      w = $urandom;
      b = 3'($urandom_range(0, 7));
      start(w, b);
      wait_done(1);
      build_model(w, b);
      verify($sformatf("rnd%0d", i), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
